// File: rtl/gfx_cmd_queue_pkg.sv
// Shared definitions for the graphics command queue: command type codes,
// queue FSM encodings and a small width helper.
package gfx_cmd_queue_pkg;

    typedef enum logic [1:0] {
        CMD_SPRITE = 2'd0,
        CMD_FONT   = 2'd1,
        CMD_BCK    = 2'd2,
        CMD_RSVD   = 2'd3
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_DRAIN   = 2'd2
    } fsm_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gfx_cmd_queue_sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and occupancy count.
// rdata always shows the head entry; a pop simply advances past it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Entry storage; contents need no reset because level guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); level tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/gfx_cmd_queue.sv
// Graphics side-effect command queue. Buffers sprite/font/background writes
// from the execute stage and replays them in order, optionally only during
// vertical blanking so a frame never shows a half-updated sprite set.
// Handshake: a command transfers on any cycle where cmd_valid and cmd_ready
// are both high; cmd_ready depends only on occupancy, never on cmd_valid.
module gfx_cmd_queue
    import gfx_cmd_queue_pkg::*;
#(
    parameter int N_SPRITES   = 32,
    parameter int DEPTH       = 8,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int FONT_AW     = 11,
    parameter int FONT_DW     = 4,
    parameter int COMMIT_MODE = 1,
    localparam int SEL_W = $clog2(N_SPRITES),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_type,
    input  logic [SEL_W-1:0]   cmd_sel,
    input  logic [31:0]        cmd_a,
    input  logic [31:0]        cmd_b,
    input  logic [2:0]         cmd_flags,
    output logic               cmd_ready,
    input  logic               vblank,
    output logic               spr_we,
    output logic [SEL_W-1:0]   spr_sel,
    output logic [X_W-1:0]     spr_x,
    output logic [Y_W-1:0]     spr_y,
    output logic               spr_attr,
    output logic               spr_pos,
    output logic               spr_vis,
    output logic               font_we,
    output logic [FONT_AW-1:0] font_addr,
    output logic [FONT_DW-1:0] font_data,
    output logic               font_ch_active,
    output logic               font_clr,
    output logic               bck_we,
    output logic [1:0]         bck,
    output logic               bck_ch_active,
    output logic [LVL_W-1:0]   level,
    output logic               overflow,
    output logic               commit_done,
    output logic [1:0]         dbg_state
);

    localparam int AW = max_int(X_W, FONT_AW);
    localparam int BW = max_int(Y_W, FONT_DW);

    typedef struct packed {
        logic [1:0]       typ;
        logic [SEL_W-1:0] sel;
        logic [AW-1:0]    a;
        logic [BW-1:0]    b;
        logic [2:0]       flags;   // {attr,pos,vis}
    } entry_t;

    entry_t     wr_entry;
    entry_t     rd_entry;
    fsm_state_e state;
    logic       vblank_q;
    logic       full;
    logic       empty;
    logic       push_en;
    logic       gate_open;
    logic       pop;
    logic       last_pop;
    logic       unused_bits;

    assign cmd_ready = ~full;
    assign push_en   = cmd_valid & ~full & (cmd_type != CMD_RSVD);
    assign gate_open = (COMMIT_MODE == 0) | vblank_q;
    assign pop       = ~empty & gate_open;
    // The pop that leaves the queue empty ends a commit.
    assign last_pop  = pop & (level == LVL_W'(1)) & ~push_en;
    assign dbg_state = state;

    assign wr_entry.typ   = cmd_type;
    assign wr_entry.sel   = cmd_sel;
    assign wr_entry.a     = cmd_a[AW-1:0];
    assign wr_entry.b     = cmd_b[BW-1:0];
    assign wr_entry.flags = cmd_flags;
    assign unused_bits    = ^{cmd_a[31:AW], cmd_b[31:BW]};

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_en),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Single-stage vblank register; the drain gate looks only at this copy.
    always_ff @(posedge clk) begin
        if (reset) vblank_q <= 1'b0;
        else       vblank_q <= vblank;
    end

    // Sticky drop flag: a real (non-reserved) command arrived while full.
    always_ff @(posedge clk) begin
        if (reset)                                               overflow <= 1'b0;
        else if (cmd_valid & full & (cmd_type != CMD_RSVD))      overflow <= 1'b1;
    end

    // Commit FSM: tracks empty / gated / draining and pulses commit_done on the final pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            commit_done <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (push_en) state <= ST_WAIT_VB;
                end
                ST_WAIT_VB: begin
                    if (last_pop) begin
                        state       <= ST_IDLE;
                        commit_done <= 1'b1;
                    end else if (gate_open) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (last_pop) begin
                        state       <= ST_IDLE;
                        commit_done <= 1'b1;
                    end else if (!gate_open) begin
                        state <= ST_WAIT_VB;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Replay the popped head entry: one strobe per pop, data held between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            spr_we         <= 1'b0;
            spr_sel        <= '0;
            spr_x          <= '0;
            spr_y          <= '0;
            spr_attr       <= 1'b0;
            spr_pos        <= 1'b0;
            spr_vis        <= 1'b0;
            font_we        <= 1'b0;
            font_addr      <= '0;
            font_data      <= '0;
            font_ch_active <= 1'b0;
            font_clr       <= 1'b0;
            bck_we         <= 1'b0;
            bck            <= '0;
            bck_ch_active  <= 1'b0;
        end else begin
            spr_we  <= 1'b0;
            font_we <= 1'b0;
            bck_we  <= 1'b0;
            if (pop) begin
                case (rd_entry.typ)
                    CMD_SPRITE: begin
                        spr_we  <= 1'b1;
                        spr_sel <= rd_entry.sel;
                        spr_x   <= rd_entry.a[X_W-1:0];
                        spr_y   <= rd_entry.b[Y_W-1:0];
                        {spr_attr, spr_pos, spr_vis} <= rd_entry.flags;
                    end
                    CMD_FONT: begin
                        font_we        <= 1'b1;
                        font_addr      <= rd_entry.a[FONT_AW-1:0];
                        font_data      <= rd_entry.b[FONT_DW-1:0];
                        font_ch_active <= rd_entry.flags[2];
                        font_clr       <= rd_entry.flags[1];
                    end
                    CMD_BCK: begin
                        bck_we        <= 1'b1;
                        bck           <= rd_entry.flags[1:0];
                        bck_ch_active <= rd_entry.flags[2];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gfx_cmd_queue.sv
// Directed bench for gfx_cmd_queue: a vblank-gated instance (dut) and a
// free-draining instance (dut0) share clock, reset and command inputs.
module tb_gfx_cmd_queue;
    import gfx_cmd_queue_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_type = 2'd0;
    logic [4:0]  cmd_sel = '0;
    logic [31:0] cmd_a = '0;
    logic [31:0] cmd_b = '0;
    logic [2:0]  cmd_flags = '0;
    logic        vblank = 1'b0;

    logic        cmd_ready, spr_we, spr_attr, spr_pos, spr_vis, font_we, font_ch_active, font_clr;
    logic        bck_we, bck_ch_active, overflow, commit_done;
    logic [4:0]  spr_sel;
    logic [9:0]  spr_x;
    logic [8:0]  spr_y;
    logic [10:0] font_addr;
    logic [3:0]  font_data;
    logic [1:0]  bck, dbg_state;
    logic [3:0]  level;

    logic        z_cmd_ready, z_spr_we, z_spr_attr, z_spr_pos, z_spr_vis, z_font_we, z_font_ch_active, z_font_clr;
    logic        z_bck_we, z_bck_ch_active, z_overflow, z_commit_done;
    logic [4:0]  z_spr_sel;
    logic [9:0]  z_spr_x;
    logic [8:0]  z_spr_y;
    logic [10:0] z_font_addr;
    logic [3:0]  z_font_data;
    logic [1:0]  z_bck, z_dbg_state;
    logic [3:0]  z_level;

    gfx_cmd_queue #(.COMMIT_MODE(1)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flags(cmd_flags), .cmd_ready(cmd_ready), .vblank(vblank),
        .spr_we(spr_we), .spr_sel(spr_sel), .spr_x(spr_x), .spr_y(spr_y), .spr_attr(spr_attr),
        .spr_pos(spr_pos), .spr_vis(spr_vis), .font_we(font_we), .font_addr(font_addr),
        .font_data(font_data), .font_ch_active(font_ch_active), .font_clr(font_clr), .bck_we(bck_we),
        .bck(bck), .bck_ch_active(bck_ch_active), .level(level), .overflow(overflow),
        .commit_done(commit_done), .dbg_state(dbg_state)
    );

    gfx_cmd_queue #(.COMMIT_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_sel(cmd_sel),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flags(cmd_flags), .cmd_ready(z_cmd_ready), .vblank(vblank),
        .spr_we(z_spr_we), .spr_sel(z_spr_sel), .spr_x(z_spr_x), .spr_y(z_spr_y), .spr_attr(z_spr_attr),
        .spr_pos(z_spr_pos), .spr_vis(z_spr_vis), .font_we(z_font_we), .font_addr(z_font_addr),
        .font_data(z_font_data), .font_ch_active(z_font_ch_active), .font_clr(z_font_clr),
        .bck_we(z_bck_we), .bck(z_bck), .bck_ch_active(z_bck_ch_active), .level(z_level),
        .overflow(z_overflow), .commit_done(z_commit_done), .dbg_state(z_dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int wr_base = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_x;

    // Strobe counter for dut, sampled on the inactive edge.
    always @(negedge clk) wr_cnt <= wr_cnt + int'(spr_we) + int'(font_we) + int'(bck_we);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic push_cmd(input logic [1:0] t, input logic [4:0] s, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] f);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_sel   = s;
        cmd_a     = a;
        cmd_b     = b;
        cmd_flags = f;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---- reset values ----
        step();
        do_reset();
        check_eq("rst_level", 32'(level), 0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rst_ready", 32'(cmd_ready), 1);
        check_eq("rst_we", 32'({spr_we, font_we, bck_we}), 0);
        check_eq("rst_ovf", 32'(overflow), 0);

        // ---- 1: single sprite waits for vblank ----
        push_cmd(2'd0, 5'd5, 32'h12C, 32'h0F0, 3'b011);
        check_eq("t1_level", 32'(level), 1);
        check_eq("t1_no_we", 32'(spr_we), 0);
        check_eq("t1_state", 32'(dbg_state), 32'(ST_WAIT_VB));
        vblank = 1'b1;
        step();
        check_eq("t1_we_early", 32'(spr_we), 0);
        step();
        check_eq("t1_spr_we", 32'(spr_we), 1);
        check_eq("t1_spr_sel", 32'(spr_sel), 5);
        check_eq("t1_spr_x", 32'(spr_x), 300);
        check_eq("t1_spr_y", 32'(spr_y), 240);
        check_eq("t1_flags", 32'({spr_attr, spr_pos, spr_vis}), 32'b011);
        check_eq("t1_other_we", 32'({font_we, bck_we}), 0);
        check_eq("t1_commit", 32'(commit_done), 1);
        step();
        check_eq("t1_we_off", 32'(spr_we), 0);
        check_eq("t1_commit_off", 32'(commit_done), 0);
        check_eq("t1_idle", 32'(dbg_state), 32'(ST_IDLE));
        vblank = 1'b0;

        // ---- reserved type is discarded ----
        do_reset();
        push_cmd(2'd3, 5'd1, 32'h1, 32'h1, 3'b111);
        check_eq("rsvd_level", 32'(level), 0);
        check_eq("rsvd_ovf", 32'(overflow), 0);

        // ---- 2: fill to full, ninth dropped ----
        do_reset();
        for (int i = 0; i < 8; i++) push_cmd(2'd0, 5'(i), 32'(i), 32'(i), 3'b001);
        check_eq("t2_ready", 32'(cmd_ready), 0);
        check_eq("t2_level8", 32'(level), 8);
        check_eq("t2_ovf_pre", 32'(overflow), 0);
        push_cmd(2'd0, 5'd9, 32'd9, 32'd9, 3'b001);
        check_eq("t2_ovf", 32'(overflow), 1);
        check_eq("t2_level", 32'(level), 8);
        step();
        check_eq("t2_ovf_sticky", 32'(overflow), 1);

        // ---- 3: mixed types commit in order ----
        do_reset();
        push_cmd(2'd0, 5'd2, 32'd5, 32'd6, 3'b001);
        push_cmd(2'd1, 5'd0, 32'h7FF, 32'hA, 3'b110);
        push_cmd(2'd2, 5'd0, 32'd0, 32'd0, 3'b110);
        check_eq("t3_level", 32'(level), 3);
        vblank = 1'b1;
        step();
        check_eq("t3_we0", 32'({spr_we, font_we, bck_we}), 0);
        step();
        check_eq("t3_we_spr", 32'({spr_we, font_we, bck_we}), 32'b100);
        check_eq("t3_spr_xy", 32'({spr_x, spr_y}), 32'({10'd5, 9'd6}));
        step();
        check_eq("t3_we_font", 32'({spr_we, font_we, bck_we}), 32'b010);
        check_eq("t3_font_addr", 32'(font_addr), 32'h7FF);
        check_eq("t3_font_data", 32'(font_data), 32'hA);
        check_eq("t3_font_flags", 32'({font_ch_active, font_clr}), 32'b11);
        step();
        check_eq("t3_we_bck", 32'({spr_we, font_we, bck_we}), 32'b001);
        check_eq("t3_bck", 32'(bck), 32'b10);
        check_eq("t3_bck_ch", 32'(bck_ch_active), 1);
        check_eq("t3_spr_hold", 32'(spr_x), 5);
        check_eq("t3_commit", 32'(commit_done), 1);
        vblank = 1'b0;

        // ---- 4: short vblank commits part of the queue ----
        do_reset();
        for (int i = 0; i < 4; i++) push_cmd(2'd0, 5'(i), 32'(10 * i), 32'd1, 3'b001);
        wr_base = wr_cnt;
        vblank = 1'b1;
        step();
        step();
        vblank = 1'b0;
        step();
        step();
        step();
        check_eq("t4_writes2", 32'(wr_cnt - wr_base), 2);
        check_eq("t4_level2", 32'(level), 2);
        check_eq("t4_state", 32'(dbg_state), 32'(ST_WAIT_VB));
        check_eq("t4_sel1", 32'(spr_sel), 1);
        check_eq("t4_x1", 32'(spr_x), 10);
        vblank = 1'b1;
        step();
        step();
        step();
        check_eq("t4_commit", 32'(commit_done), 1);
        step();
        check_eq("t4_writes4", 32'(wr_cnt - wr_base), 4);
        check_eq("t4_level0", 32'(level), 0);
        check_eq("t4_idle", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("t4_sel3", 32'(spr_sel), 3);
        check_eq("t4_x3", 32'(spr_x), 30);
        vblank = 1'b0;

        // ---- 5: free-draining instance, push and pop every cycle ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(10'(100 + i));
            push_cmd(2'd0, 5'(i), 32'(100 + i), 32'd0, 3'b001);
            check_eq("t5_level", 32'(z_level), 1);
            check_eq("t5_ready", 32'(z_cmd_ready), 1);
            if (i == 0) begin
                check_eq("t5_we_first", 32'(z_spr_we), 0);
            end else begin
                check_eq("t5_we", 32'(z_spr_we), 1);
                exp_x = exp_q.pop_front();
                check_eq("t5_x", 32'(z_spr_x), 32'(exp_x));
            end
        end
        step();
        check_eq("t5_we_last", 32'(z_spr_we), 1);
        exp_x = exp_q.pop_front();
        check_eq("t5_x_last", 32'(z_spr_x), 32'(exp_x));
        check_eq("t5_level0", 32'(z_level), 0);
        check_eq("t5_commit", 32'(z_commit_done), 1);
        check_eq("t5_q_empty", 32'(exp_q.size()), 0);

        // ---- 6: reset in the middle of a drain ----
        do_reset();
        for (int i = 0; i < 9; i++) push_cmd(2'd0, 5'(i), 32'(i), 32'd0, 3'b001);
        check_eq("t6_ovf_set", 32'(overflow), 1);
        vblank = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        check_eq("t6_level3", 32'(level), 3);
        check_eq("t6_drain", 32'(dbg_state), 32'(ST_DRAIN));
        reset = 1'b1;
        step();
        check_eq("t6_rst_level", 32'(level), 0);
        check_eq("t6_rst_we", 32'({spr_we, font_we, bck_we}), 0);
        check_eq("t6_rst_ovf", 32'(overflow), 0);
        check_eq("t6_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("t6_rst_x", 32'(spr_x), 0);
        reset = 1'b0;
        step();
        check_eq("t6_post_we", 32'({spr_we, font_we, bck_we}), 0);
        check_eq("t6_post_level", 32'(level), 0);
        vblank = 1'b0;

        // ---- report ----
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
